// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg
// Shared definitions for the round-robin 4:1 mux arbiter:
//   state_t        - arbiter FSM states (IDLE, OWN)
//   NUM_REQ, SEL_W - requester count and mux select width
//   onehot_to_idx  - converts a one-hot grant vector to its binary index
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // Returns the index of the set bit; a zero vector maps to index 0.
    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) begin
                idx = SEL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4
// Combinational rotating priority encoder for four requesters.
// Ports:
//   req   [3:0] in  - candidate request vector
//   start [1:0] in  - index with the highest priority this cycle
//   found       out - at least one request bit is set
//   idx   [1:0] out - first set request at or after start, cyclically
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   start,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] cand;

    // Scan from the lowest priority offset up to the highest so the
    // nearest request to start is the one left in idx.
    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = start;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = start + SEL_W'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
// Round-robin arbiter and sequencer for a 4:1 data mux. Owns the mux
// select, enforces a hold limit per owner, hands over back-to-back and
// registers the selected lane.
// Parameters:
//   W        - data width per requester lane
//   MAX_HOLD - max consecutive grant cycles while others wait
// Ports:
//   clk        in  - clock, rising edge
//   rst        in  - asynchronous active-high reset
//   req  [3:0] in  - level-held requests
//   d  [4*W-1:0] in - data lanes, lane i = d[i*W +: W]
//   gnt  [3:0] out - registered one-hot grant
//   sel  [1:0] out - registered binary index of the owner
//   busy       out - high while a grant is active
//   y  [W-1:0] out - registered selected data
//   y_valid    out - y was sampled under a live grant
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int W        = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*W-1:0] d,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [SEL_W-1:0]     sel,
    output logic                 busy,
    output logic [W-1:0]         y,
    output logic                 y_valid
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    state_t             state;
    logic [HW-1:0]      hold_cnt;
    logic [SEL_W-1:0]   last;

    logic [NUM_REQ-1:0] pick_vec;
    logic [SEL_W-1:0]   pick_start;
    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;
    logic               owner_req;
    logic               at_limit;
    logic               live;

    // While owning, only the other requesters compete and the search starts
    // just past the owner; from idle the search starts past the last owner.
    always_comb begin
        pick_vec    = (state == OWN) ? (req & ~gnt) : req;
        pick_start  = (state == OWN) ? (sel + SEL_W'(1)) : (last + SEL_W'(1));
        pick_onehot = NUM_REQ'(1) << pick_idx;
        owner_req   = |(req & gnt);
        at_limit    = (hold_cnt == HOLD_LAST);
        live        = gnt[sel] & req[sel];
    end

    rr_pick4 u_pick (
        .req   (pick_vec),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            sel      <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            last     <= SEL_W'(NUM_REQ - 1);
            y        <= '0;
            y_valid  <= 1'b0;
        end else begin
            // y keeps its last good value once the grant is no longer live.
            if (live) begin
                y <= d[int'(sel)*W +: W];
            end
            y_valid <= live;

            case (state)
                IDLE: begin
                    if (pick_found) begin
                        gnt      <= pick_onehot;
                        sel      <= onehot_to_idx(pick_onehot);
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                        state    <= OWN;
                    end
                end
                OWN: begin
                    if (!owner_req || (at_limit && pick_found)) begin
                        // Release or preempt: the next owner takes over on
                        // this same edge when anyone else is waiting.
                        last     <= sel;
                        hold_cnt <= '0;
                        if (pick_found) begin
                            gnt <= pick_onehot;
                            sel <= onehot_to_idx(pick_onehot);
                        end else begin
                            gnt   <= '0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (at_limit) begin
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [3:0]  req8 = '0;
    logic [31:0] d8 = '0;
    logic [3:0]  gnt8;
    logic [1:0]  sel8;
    logic        busy8;
    logic [7:0]  y8;
    logic        yv8;

    logic [3:0]  req1 = '0;
    logic [31:0] d1 = '0;
    logic [3:0]  gnt1;
    logic [1:0]  sel1;
    logic        busy1;
    logic [7:0]  y1;
    logic        yv1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.W(8), .MAX_HOLD(8)) dut (
        .clk(clk), .rst(rst), .req(req8), .d(d8),
        .gnt(gnt8), .sel(sel8), .busy(busy8), .y(y8), .y_valid(yv8)
    );

    mux_rr_arbiter #(.W(8), .MAX_HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .d(d1),
        .gnt(gnt1), .sel(sel1), .busy(busy1), .y(y1), .y_valid(yv1)
    );

    // Reference model: who owns the mux, for how many cycles, and who owned it last.
    int         m_owner[2];
    int         m_cnt[2];
    int         m_last[2];
    bit         m_act[2];
    bit         m_yv[2];
    logic [7:0] m_y[2];
    int         lim[2] = '{8, 1};

    function automatic int pick(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic [3:0]  r;
        logic [3:0]  others;
        logic [31:0] dd;
        int          w;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_act[k] = 0; m_owner[k] = 0; m_cnt[k] = 0;
                m_last[k] = 3; m_y[k] = '0; m_yv[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                r  = (k == 0) ? req8 : req1;
                dd = (k == 0) ? d8 : d1;
                if (m_act[k] && r[m_owner[k]]) begin
                    m_y[k]  = dd[m_owner[k]*8 +: 8];
                    m_yv[k] = 1;
                end else begin
                    m_yv[k] = 0;
                end
                if (!m_act[k]) begin
                    w = pick(r, (m_last[k] + 1) % 4);
                    if (w >= 0) begin
                        m_owner[k] = w; m_act[k] = 1; m_cnt[k] = 0;
                    end
                end else begin
                    others = r & ~(4'b0001 << m_owner[k]);
                    if (!r[m_owner[k]] || (m_cnt[k] == lim[k] - 1 && others != 0)) begin
                        m_last[k] = m_owner[k];
                        m_cnt[k]  = 0;
                        if (others != 0) m_owner[k] = pick(others, (m_owner[k] + 1) % 4);
                        else             m_act[k] = 0;
                    end else if (m_cnt[k] == lim[k] - 1) begin
                        m_cnt[k] = 0;
                    end else begin
                        m_cnt[k]++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r8, input logic [3:0] r1);
        req8 = r8;
        req1 = r1;
        d8   = $urandom;
        d1   = $urandom;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({gnt8, sel8, busy8, y8, yv8} !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_dut8: got gnt=%b sel=%0d busy=%b y=%h yv=%b expected all zero", gnt8, sel8, busy8, y8, yv8);
        end
        checks++;
        if ({gnt1, sel1, busy1, y1, yv1} !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_dut1: got gnt=%b sel=%0d busy=%b y=%h yv=%b expected all zero", gnt1, sel1, busy1, y1, yv1);
        end
        #2;
        rst = 1'b0;
    endtask

    task automatic test_single();
        applyReset();
        req8 = 4'b0001; req1 = '0;
        d8 = 32'h0000_0001;
        step();
        checks++;
        if (gnt8 !== 4'b0001 || sel8 !== 2'd0 || busy8 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_grant: got gnt=%b sel=%0d busy=%b expected 0001/0/1", gnt8, sel8, busy8);
        end
        step();
        checks++;
        if (y8 !== 8'h01 || yv8 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_data: got y=%h yv=%b expected 01/1", y8, yv8);
        end
        req8 = 4'b0000;
        step();
        checks++;
        if (gnt8 !== 4'b0000 || busy8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_release: got gnt=%b busy=%b expected 0000/0", gnt8, busy8);
        end
    endtask

    task automatic test_hold_rotation();
        logic [3:0] eg;
        applyReset();
        for (int i = 0; i < 40; i++) begin
            applyStimulus(4'b1111, 4'b0000);
            step();
            eg = 4'b0001 << ((i / 8) % 4);
            checks++;
            if (gnt8 !== eg || sel8 !== 2'((i / 8) % 4) || busy8 !== 1'b1) begin
                errors++;
                $display("[TB] FAIL hold_rotation cyc %0d: got gnt=%b sel=%0d busy=%b expected %b/%0d/1", i, gnt8, sel8, busy8, eg, (i / 8) % 4);
            end
        end
    endtask

    task automatic test_back_to_back();
        applyReset();
        applyStimulus(4'b0010, 4'b0000);
        step();
        checks++;
        if (gnt8 !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL b2b_first: got gnt=%b expected 0010", gnt8);
        end
        applyStimulus(4'b0110, 4'b0000);
        step();
        step();
        applyStimulus(4'b0100, 4'b0000);
        step();
        checks++;
        if (gnt8 !== 4'b0100 || busy8 !== 1'b1 || sel8 !== 2'd2) begin
            errors++;
            $display("[TB] FAIL b2b_handover: got gnt=%b busy=%b sel=%0d expected 0100/1/2", gnt8, busy8, sel8);
        end
        applyStimulus(4'b0000, 4'b0000);
        step();
        applyStimulus(4'b1111, 4'b0000);
        step();
        checks++;
        if (gnt8 !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL b2b_last_priority: got gnt=%b expected 1000", gnt8);
        end
    endtask

    task automatic test_single_long();
        applyReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'b0100, 4'b0000);
            step();
            checks++;
            if (gnt8 !== 4'b0100 || busy8 !== 1'b1) begin
                errors++;
                $display("[TB] FAIL single_long cyc %0d: got gnt=%b busy=%b expected 0100/1", i, gnt8, busy8);
            end
        end
    endtask

    task automatic test_async_reset();
        applyReset();
        applyStimulus(4'b1111, 4'b1111);
        step(); step(); step();
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({gnt8, sel8, busy8, y8, yv8} !== 16'h0 || {gnt1, sel1, busy1, y1, yv1} !== 16'h0) begin
            errors++;
            $display("[TB] FAIL async_reset: got gnt8=%b y8=%h gnt1=%b y1=%h expected zero", gnt8, y8, gnt1, y1);
        end
        #1;
        rst = 1'b0;
        step();
        checks++;
        if (gnt8 !== 4'b0001 || gnt1 !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL async_reset_first: got gnt8=%b gnt1=%b expected 0001", gnt8, gnt1);
        end
    endtask

    task automatic test_max_hold1();
        logic [31:0] prev_d;
        int          own;
        int          prev_own;
        applyReset();
        prev_own = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(4'b0000, 4'b1010);
            prev_d = d1;
            step();
            own = (i % 2 == 0) ? 1 : 3;
            checks++;
            if (gnt1 !== (4'b0001 << own) || sel1 !== 2'(own)) begin
                errors++;
                $display("[TB] FAIL hold1_alternate cyc %0d: got gnt=%b sel=%0d expected owner %0d", i, gnt1, sel1, own);
            end
            if (i > 0) begin
                checks++;
                if (yv1 !== 1'b1 || y1 !== prev_d[prev_own*8 +: 8]) begin
                    errors++;
                    $display("[TB] FAIL hold1_data cyc %0d: got y=%h yv=%b expected %h/1", i, y1, yv1, prev_d[prev_own*8 +: 8]);
                end
            end
            prev_own = own;
        end
    endtask

    task automatic test_random();
        logic [3:0] eg8;
        logic [3:0] eg1;
        applyReset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req8 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req1 = 4'($urandom_range(0, 15));
            d8 = $urandom;
            d1 = $urandom;
            step();
            eg8 = m_act[0] ? (4'b0001 << m_owner[0]) : 4'b0000;
            eg1 = m_act[1] ? (4'b0001 << m_owner[1]) : 4'b0000;
            checks++;
            if (gnt8 !== eg8 || busy8 !== (eg8 != 0) || (eg8 != 0 && sel8 !== 2'(m_owner[0]))) begin
                errors++;
                $display("[TB] FAIL rand_grant8 cyc %0d: got gnt=%b sel=%0d busy=%b expected gnt=%b sel=%0d", i, gnt8, sel8, busy8, eg8, m_owner[0]);
            end
            checks++;
            if (yv8 !== m_yv[0] || (m_yv[0] && y8 !== m_y[0])) begin
                errors++;
                $display("[TB] FAIL rand_data8 cyc %0d: got y=%h yv=%b expected y=%h yv=%b", i, y8, yv8, m_y[0], m_yv[0]);
            end
            checks++;
            if (gnt1 !== eg1 || busy1 !== (eg1 != 0) || (eg1 != 0 && sel1 !== 2'(m_owner[1]))) begin
                errors++;
                $display("[TB] FAIL rand_grant1 cyc %0d: got gnt=%b sel=%0d busy=%b expected gnt=%b sel=%0d", i, gnt1, sel1, busy1, eg1, m_owner[1]);
            end
            checks++;
            if (yv1 !== m_yv[1] || (m_yv[1] && y1 !== m_y[1])) begin
                errors++;
                $display("[TB] FAIL rand_data1 cyc %0d: got y=%h yv=%b expected y=%h yv=%b", i, y1, yv1, m_y[1], m_yv[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_hold_rotation();
        test_back_to_back();
        test_single_long();
        test_async_reset();
        test_max_hold1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
